ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage. Consumes operands and control from the ID/EX register.

---
 rtl/ex_muldiv_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit for the EX stage. Holds the architectural
//   HI/LO registers, runs MULT/MULTU/DIV/DIVU one bit per cycle and stalls
//   the pipeline while an op is in flight and something wants HI/LO or the
//   unit.
//
//   Sequence: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> IDLE, so an op
//   occupies the unit for WIDTH+1 cycles after the accepting edge.
//
//   Optional feature: define MULDIV_MADD_EN to enable op 100 MADD and
//   op 101 MSUB ({Hi,Lo} +/-= signed A*B, accumulated at the FIX edge).
//   Without it those codes are ignored like any other undefined op.
//
// Ports
//   Clk      in   rising-edge pipeline clock
//   Rst_n    in   asynchronous active-low reset
//   Start    in   request a new op
//   Op       in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//   A, B     in   rs / rt operands
//   Flush    in   abort the in-flight op (no HI/LO update, no Done)
//   Hi_We    in   MTHI write enable
//   Lo_We    in   MTLO write enable
//   Wr_Data  in   MTHI/MTLO data
//   Mf_Req   in   MFHI/MFLO in EX this cycle
//   Hi, Lo   out  architectural HI/LO registers
//   Busy     out  op in flight (registered)
//   Done     out  one-cycle pulse after HI/LO were written by an op
//   Stall    out  Busy & (Start | Mf_Req | Hi_We | Lo_We), combinational
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             Hi_We,
  input  logic             Lo_We,
  input  logic [WIDTH-1:0] Wr_Data,
  input  logic             Mf_Req,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ZERO_W   = {WIDTH{1'b0}};

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    logic ok;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ok = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MSUB:                   ok = 1'b1;
`endif
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [2:0]         op_r;
  // MUL: running product. DIV: {remainder, dividend/quotient shift register}.
  logic [2*WIDTH-1:0] work_r;
  // MUL: multiplicand magnitude. DIV: divisor magnitude.
  logic [WIDTH-1:0]   opnd_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               div0_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               signed_op_s;
  logic               div_op_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               accept_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] step_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  // Operand decode, magnitudes and accept condition for the incoming request.
  always_comb begin
    // MADD/MSUB (1xx) are signed, as are the even codes MULT and DIV.
    signed_op_s = Op[2] | ~Op[0];
    div_op_s    = (Op[2:1] == 2'b01);
    a_neg_s     = signed_op_s & A[WIDTH-1];
    b_neg_s     = signed_op_s & B[WIDTH-1];
    a_mag_s     = a_neg_s ? neg_w(A) : A;
    b_mag_s     = b_neg_s ? neg_w(B) : B;
    accept_s    = (state_r == ST_IDLE) & Start & ~Flush & op_valid(Op);
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]} +
                  (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (op_r[2:1] == 2'b01) begin
      // Negative difference (borrow) means the divisor did not fit: restore.
      if (div_diff_s[WIDTH]) begin
        step_next_s = {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
      end else begin
        step_next_s = {div_diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_next_s = {mul_sum_s, work_r[WIDTH-1:1]};
    end
  end

  // Sign correction and final HI/LO values written at the FIX edge.
  always_comb begin
    prod_s   = neg_res_r ? neg_2w(work_r) : work_r;
    quo_s    = neg_res_r ? neg_w(work_r[WIDTH-1:0]) : work_r[WIDTH-1:0];
    // With a zero divisor the remainder ends up as |A|, so this restores A.
    rem_s    = neg_rem_r ? neg_w(work_r[2*WIDTH-1:WIDTH]) : work_r[2*WIDTH-1:WIDTH];
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    case (op_r)
      OP_MULT, OP_MULTU: begin
        {res_hi_s, res_lo_s} = prod_s;
      end
      OP_DIV, OP_DIVU: begin
        res_hi_s = rem_s;
        if (div0_r) begin
          res_lo_s = {WIDTH{1'b1}};
        end else begin
          res_lo_s = quo_s;
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD: begin
        {res_hi_s, res_lo_s} = {hi_r, lo_r} + prod_s;
      end
      OP_MSUB: begin
        {res_hi_s, res_lo_s} = {hi_r, lo_r} - prod_s;
      end
`endif
      default: begin
        res_hi_s = hi_r;
        res_lo_s = lo_r;
      end
    endcase
  end

  // Control FSM, iteration datapath, HI/LO registers and status outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'b000;
      work_r    <= {(2*WIDTH){1'b0}};
      opnd_r    <= ZERO_W;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      // MTHI/MTLO only land while idle; busy writes are held off by Stall.
      if (!busy_r && Hi_We) begin
        hi_r <= Wr_Data;
      end
      if (!busy_r && Lo_We) begin
        lo_r <= Wr_Data;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r      <= Op;
            work_r    <= div_op_s ? {ZERO_W, a_mag_s} : {ZERO_W, b_mag_s};
            opnd_r    <= div_op_s ? b_mag_s : a_mag_s;
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            div0_r    <= div_op_s & (B == ZERO_W);
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (Flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            work_r <= step_next_s;
            cnt_r  <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (!Flush) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign Hi    = hi_r;
  assign Lo    = lo_r;
  assign Busy  = busy_r;
  assign Done  = done_r;
  assign Stall = busy_r & (Start | Mf_Req | Hi_We | Lo_We);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Flush;
  logic         Hi_We;
  logic         Lo_We;
  logic [W-1:0] Wr_Data;
  logic         Mf_Req;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;
  logic         Stall;

  int tests;
  int fails;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Flush(Flush), .Hi_We(Hi_We), .Lo_We(Lo_We), .Wr_Data(Wr_Data),
    .Mf_Req(Mf_Req), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Issue an op and wait (bounded) for its Done pulse; ok=0 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output bit ok);
    Op = op; A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    Hi_We = 1'b1; Wr_Data = h;
    @(negedge Clk);
    Hi_We = 1'b0; Lo_We = 1'b1; Wr_Data = l;
    @(negedge Clk);
    Lo_We = 1'b0;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Start = 1'b0; Op = 3'b000; A = 32'h0; B = 32'h0;
    Flush = 1'b0; Hi_We = 1'b0; Lo_We = 1'b0; Wr_Data = 32'h0; Mf_Req = 1'b0;
    repeat (2) @(negedge Clk);
    tests++;
    if ({Hi, Lo, Busy, Done, Stall} !== {32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: Hi=%h Lo=%h Busy=%b Done=%b Stall=%b, want all 0", Hi, Lo, Busy, Done, Stall);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_multu_full;
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0; done_cnt = 0;
    Op = 3'b001; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
      @(negedge Clk);
    end
    tests++;
    if (busy_cnt !== 33) begin
      fails++;
      $display("FAIL multu_busy_cycles: got %0d want 33", busy_cnt);
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL multu_done_cycles: got %0d want 1", done_cnt);
    end
    tests++;
    if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
      fails++;
      $display("FAIL multu_result: Hi=%h Lo=%h want FFFFFFFE 00000001", Hi, Lo);
    end
  endtask

  task automatic test_signed_ops;
    logic [2:0]   v_op [6];
    logic [W-1:0] v_a  [6];
    logic [W-1:0] v_b  [6];
    logic [W-1:0] v_hi [6];
    logic [W-1:0] v_lo [6];
    bit ok;
    // MULT -3*7, DIV -7/2, DIVU 7/0, DIV 0x80000000/-1, DIV -5/0, DIVU 100/7
    v_op[0] = 3'b000; v_a[0] = 32'hFFFF_FFFD; v_b[0] = 32'd7;         v_hi[0] = 32'hFFFF_FFFF; v_lo[0] = 32'hFFFF_FFEB;
    v_op[1] = 3'b010; v_a[1] = 32'hFFFF_FFF9; v_b[1] = 32'd2;         v_hi[1] = 32'hFFFF_FFFF; v_lo[1] = 32'hFFFF_FFFD;
    v_op[2] = 3'b011; v_a[2] = 32'd7;         v_b[2] = 32'd0;         v_hi[2] = 32'd7;         v_lo[2] = 32'hFFFF_FFFF;
    v_op[3] = 3'b010; v_a[3] = 32'h8000_0000; v_b[3] = 32'hFFFF_FFFF; v_hi[3] = 32'h0;         v_lo[3] = 32'h8000_0000;
    v_op[4] = 3'b010; v_a[4] = 32'hFFFF_FFFB; v_b[4] = 32'd0;         v_hi[4] = 32'hFFFF_FFFB; v_lo[4] = 32'hFFFF_FFFF;
    v_op[5] = 3'b011; v_a[5] = 32'd100;       v_b[5] = 32'd7;         v_hi[5] = 32'd2;         v_lo[5] = 32'd14;
    for (int i = 0; i < 6; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], ok);
      tests++;
      if (!ok || Hi !== v_hi[i] || Lo !== v_lo[i]) begin
        fails++;
        $display("FAIL op_vec%0d: done=%b Hi=%h Lo=%h want Hi=%h Lo=%h", i, ok, Hi, Lo, v_hi[i], v_lo[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_flush;
    int done_cnt;
    write_hilo(32'h11, 32'h22);
    Op = 3'b011; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (9) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_busy: Busy=%b want 0", Busy);
    end
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) done_cnt++;
      @(negedge Clk);
    end
    tests++;
    if (done_cnt !== 0 || Hi !== 32'h11 || Lo !== 32'h22) begin
      fails++;
      $display("FAIL flush_result: done_pulses=%0d Hi=%h Lo=%h want 0 11 22", done_cnt, Hi, Lo);
    end
    // Flush together with Start in IDLE must not accept.
    Op = 3'b001; A = 32'd3; B = 32'd3; Start = 1'b1; Flush = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_start_idle: Busy=%b want 0", Busy);
    end
  endtask

  task automatic test_back_to_back;
    int stall_cyc;
    int stall_bad;
    bit ok;
    Op = 3'b011; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(negedge Clk);
    // Hold Start with a second op and request MFHI/MFLO while busy.
    Op = 3'b001; A = 32'd3; B = 32'd5; Mf_Req = 1'b1;
    stall_cyc = 0; stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (!Busy) break;
      stall_cyc++;
      if (Stall !== 1'b1) stall_bad++;
      @(negedge Clk);
    end
    tests++;
    if (stall_cyc !== 33 || stall_bad !== 0) begin
      fails++;
      $display("FAIL b2b_stall: busy_cycles=%0d stall_low=%0d want 33 0", stall_cyc, stall_bad);
    end
    tests++;
    if (Done !== 1'b1 || Stall !== 1'b0 || Hi !== 32'd2 || Lo !== 32'd14) begin
      fails++;
      $display("FAIL b2b_first_result: Done=%b Stall=%b Hi=%h Lo=%h want 1 0 2 e", Done, Stall, Hi, Lo);
    end
    @(negedge Clk);
    Start = 1'b0; Mf_Req = 1'b0;
    tests++;
    if (Busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_accept: Busy=%b want 1", Busy);
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    tests++;
    if (!ok || Hi !== 32'd0 || Lo !== 32'd15) begin
      fails++;
      $display("FAIL b2b_second_result: done=%b Hi=%h Lo=%h want 0 f", ok, Hi, Lo);
    end
    @(negedge Clk);
  endtask

  task automatic test_mt_writes;
    bit ok;
    Lo_We = 1'b1; Wr_Data = 32'h1234;
    @(negedge Clk);
    Lo_We = 1'b0;
    tests++;
    if (Lo !== 32'h1234) begin
      fails++;
      $display("FAIL mtlo_idle: Lo=%h want 00001234", Lo);
    end
    // MTHI in the same cycle as an accepted Start.
    Hi_We = 1'b1; Wr_Data = 32'hAAAA; Op = 3'b001; A = 32'd2; B = 32'd3; Start = 1'b1;
    @(negedge Clk);
    Hi_We = 1'b0; Start = 1'b0;
    tests++;
    if (Hi !== 32'hAAAA || Busy !== 1'b1) begin
      fails++;
      $display("FAIL mthi_with_start: Hi=%h Busy=%b want 0000aaaa 1", Hi, Busy);
    end
    // MTLO while busy: stalled and dropped.
    Lo_We = 1'b1; Wr_Data = 32'h5555;
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++;
      $display("FAIL mtlo_busy_stall: Stall=%b want 1", Stall);
    end
    @(negedge Clk);
    Lo_We = 1'b0;
    tests++;
    if (Lo !== 32'h1234) begin
      fails++;
      $display("FAIL mtlo_busy_nowrite: Lo=%h want 00001234", Lo);
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    tests++;
    if (!ok || Hi !== 32'd0 || Lo !== 32'd6) begin
      fails++;
      $display("FAIL mt_then_op_result: done=%b Hi=%h Lo=%h want 0 6", ok, Hi, Lo);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_op;
    int done_cnt;
    int busy_cnt;
    write_hilo(32'h55, 32'h66);
    Op = 3'b000; A = 32'hFFFF_FFFD; B = 32'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    tests++;
    if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_op: Hi=%h Lo=%h Busy=%b want 0 0 0", Hi, Lo, Busy);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
      @(negedge Clk);
    end
    tests++;
    if (done_cnt !== 0 || busy_cnt !== 0) begin
      fails++;
      $display("FAIL reset_release: done_pulses=%0d busy_cycles=%0d want 0 0", done_cnt, busy_cnt);
    end
  endtask

  task automatic test_madd;
`ifdef MULDIV_MADD_EN
    bit ok;
    write_hilo(32'h0, 32'h5);
    run_op(3'b100, 32'd2, 32'd3, ok);
    tests++;
    if (!ok || Hi !== 32'h0 || Lo !== 32'h0000_000B) begin
      fails++;
      $display("FAIL madd: done=%b Hi=%h Lo=%h want 0 b", ok, Hi, Lo);
    end
    @(negedge Clk);
    run_op(3'b101, 32'd4, 32'd4, ok);
    tests++;
    if (!ok || Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFB) begin
      fails++;
      $display("FAIL msub: done=%b Hi=%h Lo=%h want ffffffff fffffffb", ok, Hi, Lo);
    end
    @(negedge Clk);
`else
    Op = 3'b100; A = 32'd2; B = 32'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL madd_disabled: Busy=%b want 0", Busy);
    end
`endif
    Op = 3'b111; A = 32'd2; B = 32'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    tests++;
    if (Busy !== 1'b0) begin
      fails++;
      $display("FAIL undefined_op: Busy=%b want 0", Busy);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_multu_full();
    test_signed_ops();
    test_flush();
    test_back_to_back();
    test_mt_writes();
    test_reset_mid_op();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
